// File: rtl/fifo_rd_drain_if.sv
// Bus bundles for the read-side FIFO drain: the FIFO read port and the
// downstream valid/ready stream. The master side is the drain logic.
interface fifo_rd_if #(
    parameter int unsigned DATA_WIDTH = 12
);
    logic                  fifo_empty;
    logic                  fifo_almost_empty;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        input  fifo_empty,
        input  fifo_almost_empty,
        input  rd_data,
        output rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_almost_empty,
        output rd_data,
        input  rd_en
    );
endinterface

interface stream_if #(
    parameter int unsigned DATA_WIDTH = 12
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-domain drain of an async FIFO into a 2-entry skid buffer with a valid/ready output.
// Define FIFO_RD_DRAIN_STATS_EN to add word/stall/starve counters (and CNT_WIDTH).
module fifo_rd_drain #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned BURST_LEN  = 4
`ifdef FIFO_RD_DRAIN_STATS_EN
    , parameter int unsigned CNT_WIDTH = 16
`endif
) (
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    input  logic             drain_enable,
    fifo_rd_if.master        fifo,
    stream_if.master         strm,
`ifdef FIFO_RD_DRAIN_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] starve_count,
`endif
    output logic             drain_idle
);

    typedef enum logic {ST_IDLE, ST_READ} state_e;

    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

    state_e                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic                  gap_q, gap_d;
    logic [7:0]            burst_cnt_q, burst_cnt_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf0_d, buf1_d;
    logic [1:0]            wr_idx;
    logic                  pop, room, rd_en_c;

    assign pop  = (occ_q != 2'd0) & strm.m_ready;
    // Buffered words plus the one arriving now, minus the one leaving, must leave a free slot.
    assign room = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    // rd_en is a combinational gate so dropping drain_enable or hitting empty stops reads at once.
    assign rd_en_c = (state_q == ST_READ) & ~fifo.fifo_empty & drain_enable & room & ~gap_q
                   & (~fifo.fifo_almost_empty | ~inflight_q);

    assign fifo.rd_en   = rd_en_c;
    assign strm.m_valid = (occ_q != 2'd0);
    assign strm.m_data  = buf_q[0];
    assign drain_idle   = (state_q == ST_IDLE) & (occ_q == 2'd0) & ~inflight_q;
    assign wr_idx       = occ_q - {1'b0, pop};

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        gap_d       = 1'b0;
        occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        buf0_d      = buf_q[0];
        buf1_d      = buf_q[1];

        unique case (state_q)
            ST_IDLE: if (drain_enable && !fifo.fifo_empty) state_d = ST_READ;
            ST_READ: if (!drain_enable || (fifo.fifo_empty && !rd_en_c)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_READ || fifo.fifo_almost_empty) begin
            burst_cnt_d = 8'd0;
        end else if (rd_en_c) begin
            if (burst_cnt_q == BURST_LAST) begin
                burst_cnt_d = 8'd0;
                gap_d       = 1'b1;
            end else begin
                burst_cnt_d = burst_cnt_q + 8'd1;
            end
        end

        // Head lives in entry 0; a pop shifts entry 1 forward before the new word lands behind it.
        if (pop) buf0_d = buf_q[1];
        if (inflight_q) begin
            if (wr_idx == 2'd0) buf0_d = fifo.rd_data;
            else                buf1_d = fifo.rd_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q     <= ST_IDLE;
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            gap_q       <= 1'b0;
            burst_cnt_q <= 8'd0;
            // NOTE: the two buffer entries are reset because entry 0 drives m_data directly.
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            inflight_q  <= rd_en_c;
            gap_q       <= gap_d;
            burst_cnt_q <= burst_cnt_d;
            buf_q[0]    <= buf0_d;
            buf_q[1]    <= buf1_d;
        end
    end

`ifdef FIFO_RD_DRAIN_STATS_EN
    logic [CNT_WIDTH-1:0] word_count_q, stall_count_q, starve_count_q;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            word_count_q   <= '0;
            stall_count_q  <= '0;
            starve_count_q <= '0;
        end else if (stats_clr) begin
            word_count_q   <= '0;
            stall_count_q  <= '0;
            starve_count_q <= '0;
        end else begin
            if (pop && word_count_q != '1)
                word_count_q <= word_count_q + CNT_WIDTH'(1);
            if (strm.m_valid && !strm.m_ready && stall_count_q != '1)
                stall_count_q <= stall_count_q + CNT_WIDTH'(1);
            if (state_q == ST_READ && fifo.fifo_empty && starve_count_q != '1)
                starve_count_q <= starve_count_q + CNT_WIDTH'(1);
        end
    end

    assign word_count   = word_count_q;
    assign stall_count  = stall_count_q;
    assign starve_count = starve_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: a queue-based FIFO/stream model checked every
// cycle, plus directed scenarios with hand-computed rd_en patterns and counts.
module tb_fifo_rd_drain;
    localparam int DW = 12;

    logic rd_clk       = 1'b0;
    logic rd_rst_n     = 1'b0;
    logic drain_enable = 1'b0;
    logic drain_idle;

    fifo_rd_if #(.DATA_WIDTH(DW)) fifo_bus ();
    stream_if  #(.DATA_WIDTH(DW)) m_bus ();

`ifdef FIFO_RD_DRAIN_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] word_count, stall_count, starve_count;
`endif

    fifo_rd_drain #(
        .DATA_WIDTH(DW),
        .BURST_LEN (4)
`ifdef FIFO_RD_DRAIN_STATS_EN
        , .CNT_WIDTH(16)
`endif
    ) dut (
        .rd_clk      (rd_clk),
        .rd_rst_n    (rd_rst_n),
        .drain_enable(drain_enable),
        .fifo        (fifo_bus),
        .strm        (m_bus),
`ifdef FIFO_RD_DRAIN_STATS_EN
        .stats_clr   (stats_clr),
        .word_count  (word_count),
        .stall_count (stall_count),
        .starve_count(starve_count),
`endif
        .drain_idle  (drain_idle)
    );

    always #5 rd_clk = ~rd_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO contents, words read but not yet delivered, and scenario tallies.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            rd_log[$];
    bit            rd_pend = 1'b0;
    logic [DW-1:0] rd_word = '0;
    bit            prev_rd = 1'b0;
    bit            consec  = 1'b0;
    int            rd_cnt  = 0;
    int            pop_cnt = 0;

    // FIFO model: read data appears one cycle after rd_en; empty tracks the queue.
    initial begin
        fifo_bus.fifo_empty = 1'b1;
        fifo_bus.rd_data    = '0;
        forever begin
            @(posedge rd_clk);
            #1;
            fifo_bus.rd_data    = rd_pend ? rd_word : 12'hBAD;
            fifo_bus.fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Compare process: the output stream must be exactly the words read, in order.
    always @(negedge rd_clk) begin : cmp
        bit exp_valid;
        if (!rd_rst_n) begin
            exp_q.delete();
            rd_pend = 1'b0;
            prev_rd = 1'b0;
            check("rst_m_valid", {31'b0, m_bus.m_valid}, 32'd0);
            check("rst_rd_en", {31'b0, fifo_bus.rd_en}, 32'd0);
        end else begin
            exp_valid = (exp_q.size() != 0);
            check("m_valid", {31'b0, m_bus.m_valid}, {31'b0, exp_valid});
            if (exp_valid) check("m_data", {20'b0, m_bus.m_data}, {20'b0, exp_q[0]});
            check("read_when_empty", {31'b0, fifo_bus.rd_en & fifo_bus.fifo_empty}, 32'd0);
            check("rd_en_disabled", {31'b0, fifo_bus.rd_en & ~drain_enable}, 32'd0);
            rd_log.push_back(fifo_bus.rd_en);
            if (fifo_bus.rd_en) begin
                rd_cnt++;
                if (prev_rd) consec = 1'b1;
            end
            prev_rd = fifo_bus.rd_en;
            if (exp_valid && m_bus.m_ready) begin
                void'(exp_q.pop_front());
                pop_cnt++;
            end
            if (rd_pend) exp_q.push_back(rd_word);
            check("occ_le_2", {31'b0, exp_q.size() <= 2}, 32'd1);
            rd_pend = fifo_bus.rd_en;
            if (fifo_bus.rd_en) rd_word = (fifo_q.size() != 0) ? fifo_q.pop_front() : '0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge rd_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rd_rst_n = 1'b0;
        drain_enable = 1'b0;
        m_bus.m_ready = 1'b0;
        fifo_bus.fifo_almost_empty = 1'b0;
        fifo_q.delete();
        tick(2);
        check("reset_rd_en", {31'b0, fifo_bus.rd_en}, 32'd0);
        check("reset_m_valid", {31'b0, m_bus.m_valid}, 32'd0);
        check("reset_m_data", {20'b0, m_bus.m_data}, 32'd0);
        check("reset_drain_idle", {31'b0, drain_idle}, 32'd1);
        rd_rst_n = 1'b1;
        rd_cnt = 0;
        pop_cnt = 0;
        consec = 1'b0;
        rd_log.delete();
        tick(1);
    endtask

    task automatic load(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int c = 0;
        while (pop_cnt < n && c < budget) begin
            tick();
            c++;
        end
        if (pop_cnt < n) check(name, pop_cnt, n);
    endtask

    // First 7 rd_en samples starting at the first asserted one, oldest in the MSB.
    function automatic logic [6:0] first7();
        int i = 0;
        logic [6:0] p = '0;
        while (i < rd_log.size() && !rd_log[i]) i++;
        for (int k = 0; k < 7; k++)
            p = {p[5:0], (i + k < rd_log.size()) ? rd_log[i + k] : 1'b0};
        return p;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fifo_bus.fifo_almost_empty = 1'b0;
        m_bus.m_ready = 1'b0;

        // Burst mode, no backpressure: 4 reads, a gap, 2 reads; words in order.
        do_reset();
        load(12'h001, 6);
        m_bus.m_ready = 1'b1;
        drain_enable = 1'b1;
        wait_pops(6, 40, "t1_pops_timeout");
        check("t1_rd_pattern", {25'b0, first7()}, {25'b0, 7'b1111011});
        check("t1_rd_count", rd_cnt, 6);
        begin
            int k = 0;
            while (!drain_idle && k < 3) begin
                tick();
                k++;
            end
        end
        check("t1_idle", {31'b0, drain_idle}, 32'd1);

        // Backpressure: buffer fills after 2 reads, head held, then full drain.
        do_reset();
        load(12'h001, 6);
        drain_enable = 1'b1;
        tick(10);
        check("t2_rd_count_stalled", rd_cnt, 2);
        check("t2_valid_held", {31'b0, m_bus.m_valid}, 32'd1);
        check("t2_head_held", {20'b0, m_bus.m_data}, 32'h001);
        m_bus.m_ready = 1'b1;
        wait_pops(6, 40, "t2_pops_timeout");
        tick(5);
        check("t2_pop_count", pop_cnt, 6);
        check("t2_rd_count", rd_cnt, 6);
        check("t2_idle", {31'b0, drain_idle}, 32'd1);

        // Single mode: never two reads in consecutive cycles.
        do_reset();
        fifo_bus.fifo_almost_empty = 1'b1;
        load(12'h0A1, 3);
        m_bus.m_ready = 1'b1;
        drain_enable = 1'b1;
        wait_pops(3, 40, "t3_pops_timeout");
        check("t3_no_consecutive", {31'b0, consec}, 32'd0);
        check("t3_rd_pattern", {25'b0, first7()}, {25'b0, 7'b1010100});
        check("t3_rd_count", rd_cnt, 3);

        // drain_enable dropped right after the first read: that word still arrives.
        do_reset();
        load(12'h101, 6);
        m_bus.m_ready = 1'b1;
        drain_enable = 1'b1;
        for (int c = 0; c < 20 && rd_cnt < 1; c++) tick();
        drain_enable = 1'b0;
        tick(8);
        check("t4_rd_count", rd_cnt, 1);
        check("t4_pop_count", pop_cnt, 1);
        check("t4_idle", {31'b0, drain_idle}, 32'd1);
        check("t4_no_valid", {31'b0, m_bus.m_valid}, 32'd0);

        // Asynchronous reset with a full buffer: outputs clear at once, nothing stale after.
        do_reset();
        load(12'h301, 6);
        drain_enable = 1'b1;
        tick(6);
        check("t5_pre_valid", {31'b0, m_bus.m_valid}, 32'd1);
        #2;
        rd_rst_n = 1'b0;
        #1;
        check("t5_async_valid", {31'b0, m_bus.m_valid}, 32'd0);
        check("t5_async_rd_en", {31'b0, fifo_bus.rd_en}, 32'd0);
        check("t5_async_idle", {31'b0, drain_idle}, 32'd1);
        fifo_q.delete();
        tick(2);
        rd_rst_n = 1'b1;
        m_bus.m_ready = 1'b1;
        pop_cnt = 0;
        tick(10);
        check("t5_no_stale_pop", pop_cnt, 0);
        check("t5_no_stale_valid", {31'b0, m_bus.m_valid}, 32'd0);

`ifdef FIFO_RD_DRAIN_STATS_EN
        // Statistics: 6 words with exactly 3 stall cycles, then a clear.
        do_reset();
        stats_clr = 1'b0;
        load(12'h201, 6);
        drain_enable = 1'b1;
        for (int c = 0; c < 20 && !m_bus.m_valid; c++) tick();
        tick(3);
        m_bus.m_ready = 1'b1;
        wait_pops(6, 40, "t6_pops_timeout");
        tick(2);
        check("t6_word_count", {16'b0, word_count}, 32'd6);
        check("t6_stall_count", {16'b0, stall_count}, 32'd3);
        check("t6_starve_seen", {31'b0, starve_count != 16'd0}, 32'd1);
        stats_clr = 1'b1;
        tick(1);
        stats_clr = 1'b0;
        check("t6_clr_word", {16'b0, word_count}, 32'd0);
        check("t6_clr_stall", {16'b0, stall_count}, 32'd0);
        check("t6_clr_starve", {16'b0, starve_count}, 32'd0);
`endif

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
